// File: rtl/tdm_demux1x8_if.sv
// Signal bundle for tdm_demux1x8. Defining TDM_DEMUX_PARITY_EN widens slot to 4 bits and adds par_err.
interface tdm_demux1x8_if;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W = 4;
`else
    localparam int SLOT_W = 3;
`endif

    // din_valid qualifies din and frame_sync on a rising clk edge; there is no
    // backpressure, so every cycle with din_valid=1 consumes one bit.
    logic              din;
    logic              din_valid;
    logic              frame_sync;
    logic [7:0]        out;
    logic              out_valid;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic              sync_err;

`ifdef TDM_DEMUX_PARITY_EN
    logic              par_err;

    modport master (
        output din, din_valid, frame_sync,
        input  out, out_valid, slot, locked, sync_err, par_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output out, out_valid, slot, locked, sync_err, par_err
    );
`else
    modport master (
        output din, din_valid, frame_sync,
        input  out, out_valid, slot, locked, sync_err
    );
    modport slave (
        input  din, din_valid, frame_sync,
        output out, out_valid, slot, locked, sync_err
    );
`endif
endinterface

// File: rtl/tdm_demux1x8.sv
// Serial TDM to 8-bit parallel demux with frame_sync alignment (HUNT/LOCKED FSM).
// TDM_DEMUX_PARITY_EN adds a ninth even-parity slot that gates the output update.
module tdm_demux1x8 (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux1x8_if.slave bus
);
`ifdef TDM_DEMUX_PARITY_EN
    localparam int SLOT_W = 4;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(8);
`else
    localparam int SLOT_W = 3;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(7);
`endif
    localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [7:0]        shadow_q, shadow_d;
    logic [7:0]        out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              sync_err_q, sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_d   = 1'b0;
`endif
        if (bus.din_valid) begin
            case (state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        state_d  = LOCKED;
                        shadow_d = {7'd0, bus.din};
                        slot_d   = SLOT_ONE;
                    end
                end
                LOCKED: begin
                    // A misplaced sync restarts the frame; the partial frame is dropped.
                    if (bus.frame_sync && slot_q != '0) begin
                        shadow_d   = {7'd0, bus.din};
                        slot_d     = SLOT_ONE;
                        sync_err_d = 1'b1;
                    end else if (slot_q == LAST_SLOT) begin
                        slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                        if (bus.din == ^shadow_q) begin
                            out_d       = shadow_q;
                            out_valid_d = 1'b1;
                        end else begin
                            par_err_d   = 1'b1;
                        end
`else
                        shadow_d[7] = bus.din;
                        out_d       = {bus.din, shadow_q[6:0]};
                        out_valid_d = 1'b1;
`endif
                    end else begin
                        shadow_d[slot_q[2:0]] = bus.din;
                        slot_d                = slot_q + SLOT_ONE;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            shadow_q    <= 8'h00;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shadow_q    <= shadow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
`ifdef TDM_DEMUX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.slot      = slot_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.sync_err  = sync_err_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.par_err   = par_err_q;
`endif
endmodule

// File: tb/tb_tdm_demux1x8.sv
// Scoreboard bench for tdm_demux1x8 (default 8-slot build): directed frames, async reset and random traffic.
module tb_tdm_demux1x8;
    logic clk;
    logic rst_n;

    tdm_demux1x8_if bus ();

    tdm_demux1x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];   // frames the model says must appear on out
    logic       err_q[$];   // sync_err pulses the model expects

    // Reference model: a stream view of the link.
    bit         hunting;
    bit         cur[$];     // bits collected since the last frame boundary
    logic [7:0] model_out;  // value out must hold between pulses

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hunting   = 1'b1;
        cur.delete();
        exp_q.delete();
        err_q.delete();
        model_out = 8'h00;
    endfunction

    function automatic void model_step(input bit d, input bit v, input bit s);
        logic [7:0] val;
        if (!v) return;
        if (s) begin
            if (!hunting && cur.size() != 0) err_q.push_back(1'b1);
            cur.delete();
            cur.push_back(d);
            hunting = 1'b0;
        end else if (!hunting) begin
            cur.push_back(d);
            if (cur.size() == 8) begin
                val = 8'h00;
                for (int k = 0; k < 8; k++) val = val + (8'(cur[k]) << k);
                exp_q.push_back(val);
                cur.delete();
            end
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit d, input bit v, input bit s);
        @(negedge clk);
        bus.din        = d;
        bus.din_valid  = v;
        bus.frame_sync = s;
        @(posedge clk);
        model_step(d, v, s);
        #1;
        check("slot",   32'(bus.slot),   32'(hunting ? 0 : cur.size()));
        check("locked", 32'(bus.locked), 32'(!hunting));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_frame(input logic [7:0] v, input bit sync, input int gap_after, input int gap_len);
        for (int k = 0; k < 8; k++) begin
            drive(v[k], 1'b1, sync && (k == 0));
            if (k == gap_after) idle(gap_len);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out"},       32'(bus.out),       32'h00);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h0);
        check({tag, "_slot"},      32'(bus.slot),      32'h0);
        check({tag, "_locked"},    32'(bus.locked),    32'h0);
        check({tag, "_sync_err"},  32'(bus.sync_err),  32'h0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 32'(bus.out_valid), 32'h0);
                end else begin
                    model_out = exp_q.pop_front();
                    check("frame_out", 32'(bus.out), 32'(model_out));
                end
            end else begin
                if (exp_q.size() != 0) begin
                    check("missing_out_valid", 32'(bus.out_valid), 32'h1);
                    void'(exp_q.pop_front());
                end
                check("out_hold", 32'(bus.out), 32'(model_out));
            end
            if (bus.sync_err) begin
                if (err_q.size() == 0) check("unexpected_sync_err", 32'(bus.sync_err), 32'h0);
                else begin
                    void'(err_q.pop_front());
                    checks++;
                end
            end else if (err_q.size() != 0) begin
                check("missing_sync_err", 32'(bus.sync_err), 32'h1);
                void'(err_q.pop_front());
            end
            if (bus.out_valid && bus.sync_err)
                check("valid_and_err_together", 32'h1, 32'h0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        rst_n          = 1'b0;
        bus.din        = 1'b0;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;
        #3;
        check_reset_values("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // No sync ever: must stay in HUNT with out at zero.
        for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 1'b0);
        check("hunt_locked", 32'(bus.locked), 32'h0);
        check("hunt_out",    32'(bus.out),    32'h00);

        // Serial 1,0,1,1,0,0,1,0 slot 0 first.
        send_frame(8'h4D, 1'b1, -1, 0);
        check("frame_4d_out",     32'(bus.out),       32'h4D);
        check("frame_4d_pulse",   32'(bus.out_valid), 32'h1);
        check("frame_4d_slot",    32'(bus.slot),      32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check("frame_4d_onepulse", 32'(bus.out_valid), 32'h0);

        // Back-to-back frames, second without a fresh sync.
        send_frame(8'hA5, 1'b1, -1, 0);
        send_frame(8'h3C, 1'b0, -1, 0);
        check("b2b_out", 32'(bus.out), 32'h3C);

        // Three-cycle bubble after slot 4.
        send_frame(8'hA5, 1'b0, 4, 3);
        check("gap_out", 32'(bus.out), 32'hA5);

        // Misplaced sync at slot 5, then a full 0xFF frame starting with that sync.
        for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b0);
        check("pre_resync_slot", 32'(bus.slot), 32'h5);
        send_frame(8'hFF, 1'b1, -1, 0);
        check("resync_out", 32'(bus.out), 32'hFF);

        // Sync exactly at slot 0 while locked is a normal frame start.
        send_frame(8'h96, 1'b1, -1, 0);

        // Asynchronous reset at slot 3, away from any clock edge.
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0);
        check("pre_reset_slot", 32'(bus.slot), 32'h3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("async");
        @(posedge clk);
        #1;
        check_reset_values("held");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0);
        check("post_reset_locked", 32'(bus.locked), 32'h0);

        // Randomised traffic: sparse syncs, occasional bubbles.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 15) == 0));
        for (int i = 0; i < 6; i++) send_frame(8'($urandom), (i == 0), -1, 0);

        idle(4);
        check("pending_frames",    32'(exp_q.size()), 32'h0);
        check("pending_sync_errs", 32'(err_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
